// File: rtl/scic_mmio_pkg.sv
// Shared definitions for the SCIC memory-mapped controller: FSM encoding and
// the I/O window layout (channel pairs followed by the edge status register).
package scic_mmio_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int OUT_OFS   = 32'd0;
   localparam int IN_OFS    = 32'd1;
   localparam int CH_STRIDE = 32'd2;

   // The status register sits directly after the last channel pair.
   function automatic int status_ofs(input int nch);
      return CH_STRIDE * nch;
   endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop synchroniser for one GPIO input channel plus a previous-value
// register used to detect rising edges of the synchronised value.
module gpio_sync_edge #(
   parameter int GW = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [GW-1:0] async_in,
   output logic [GW-1:0] sync_out,
   output logic [GW-1:0] rise_pulse
);

   logic [GW-1:0] meta_q;
   logic [GW-1:0] sync_q;
   logic [GW-1:0] prev_q;

   // Synchroniser chain and edge history
   always_ff @(posedge clock) begin
      if (!reset) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_out   = sync_q;
   assign rise_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/mmio_mem_controller.sv
// CPU word-access controller: internal RAM plus NCH GPIO channel pairs and a
// W1C edge status register, behind a req/ready handshake with wait states.
module mmio_mem_controller #(
   parameter int                DW          = 32,
   parameter int                AW          = 16,
   parameter int                DEPTH       = 1024,
   parameter int                NCH         = 2,
   parameter int                GW          = 4,
   parameter logic [AW-1:0]     IO_BASE     = 16'hFF00,
   parameter int                WAIT_STATES = 1,
   parameter logic [GW-1:0]     OUT_RESET   = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DW-1:0]     wdata,
   output logic [DW-1:0]     rdata,
   output logic              ready,
   output logic              err,
   output logic [NCH*GW-1:0] gpio_out,
   input  logic [NCH*GW-1:0] gpio_in
);
   import scic_mmio_pkg::*;

   localparam int            GPW      = NCH * GW;
   localparam int            RAW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]    CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam logic [AW-1:0] DEPTH_A  = AW'(DEPTH);
   localparam logic [AW-1:0] STAT_OFS = AW'(status_ofs(NCH));

   state_e         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic           we_q;
   logic [AW-1:0]  addr_q;
   logic [DW-1:0]  wdata_q;
   logic [DW-1:0]  rdata_q, rdata_d;
   logic           err_q, err_d;
   logic [GPW-1:0] gpio_q, gpio_d;
   logic [GPW-1:0] stat_q, clr_s;
   logic [GPW-1:0] sync_s, rise_s;
   logic [DW-1:0]  mem_q [DEPTH];

   logic           accept_s, fire_s, ram_we_s, hit_s;
   logic           cur_we_s;
   logic [AW-1:0]  cur_addr_s, io_off_s;
   logic [DW-1:0]  cur_wdata_s;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      gpio_sync_edge #(.GW(GW)) u_sync (
         .clock      (clock),
         .reset      (reset),
         .async_in   (gpio_in[i*GW +: GW]),
         .sync_out   (sync_s[i*GW +: GW]),
         .rise_pulse (rise_s[i*GW +: GW])
      );
   end

   assign accept_s = (state_q == IDLE) && req;
   assign fire_s   = (state_d == RESP);

   // With zero wait states the access completes on the accept edge, so decode the live inputs.
   assign cur_we_s    = accept_s ? we    : we_q;
   assign cur_addr_s  = accept_s ? addr  : addr_q;
   assign cur_wdata_s = accept_s ? wdata : wdata_q;
   assign io_off_s    = cur_addr_s - IO_BASE;

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = (WAIT_STATES > 0) ? WAIT : RESP;
               cnt_d   = CNT_INIT;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Address decode, read mux and write effects of the current transaction
   always_comb begin
      gpio_d   = gpio_q;
      clr_s    = '0;
      rdata_d  = '0;
      err_d    = 1'b0;
      ram_we_s = 1'b0;
      hit_s    = 1'b0;
      if (cur_addr_s < DEPTH_A) begin
         if (cur_we_s) begin
            ram_we_s = 1'b1;
         end else begin
            rdata_d = mem_q[cur_addr_s[RAW-1:0]];
         end
      end else if (cur_addr_s >= IO_BASE) begin
         for (int i = 0; i < NCH; i++) begin
            if (io_off_s == AW'(CH_STRIDE * i + OUT_OFS)) begin
               hit_s = 1'b1;
               if (cur_we_s) begin
                  gpio_d[i*GW +: GW] = cur_wdata_s[GW-1:0];
               end else begin
                  rdata_d = DW'(gpio_q[i*GW +: GW]);
               end
            end else if (io_off_s == AW'(CH_STRIDE * i + IN_OFS)) begin
               hit_s = 1'b1;
               if (cur_we_s) begin
                  err_d = 1'b1;
               end else begin
                  rdata_d = DW'(sync_s[i*GW +: GW]);
               end
            end else begin
               hit_s = hit_s;
            end
         end
         if (io_off_s == STAT_OFS) begin
            hit_s = 1'b1;
            if (cur_we_s) begin
               clr_s = cur_wdata_s[GPW-1:0];
            end else begin
               rdata_d = DW'(stat_q);
            end
         end else begin
            hit_s = hit_s;
         end
         if (!hit_s) begin
            err_d = 1'b1;
         end else begin
            err_d = err_d;
         end
      end else begin
         err_d = 1'b1;
      end
   end

   // State, capture and I/O registers; a new edge beats a same-cycle clear
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         gpio_q  <= {NCH{OUT_RESET}};
         stat_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept_s) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
         end
         if (fire_s) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
            gpio_q  <= gpio_d;
         end
         stat_q <= (stat_q & ~(fire_s ? clr_s : '0)) | rise_s;
      end
   end

   // RAM array keeps its contents through reset
   always_ff @(posedge clock) begin
      if (reset && fire_s && ram_we_s) begin
         mem_q[cur_addr_s[RAW-1:0]] <= cur_wdata_s;
      end
   end

   // Response outputs are only driven during the RESP cycle
   always_comb begin
      ready = (state_q == RESP);
      if (state_q == RESP) begin
         rdata = rdata_q;
         err   = err_q;
      end else begin
         rdata = '0;
         err   = 1'b0;
      end
   end

   assign gpio_out = gpio_q;

endmodule
